// File: rtl/xorn_stream.sv
// Streaming bitwise XOR/XNOR/AND/OR unit with per-frame XOR checksum, word count and overflow.
// Optional: define XORN_STREAM_PARITY_EN to add a registered parity output 'par'.
module xorn_stream #(
  parameter int unsigned N  = 16,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic [1:0]    op,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [N-1:0]  f,
  output logic          out_valid,
  output logic          out_last,
  input  logic          out_ready,
  output logic [N-1:0]  chk,
  output logic [CW-1:0] cnt,
`ifdef XORN_STREAM_PARITY_EN
  output logic          par,
`endif
  output logic          ovf
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  typedef enum logic {IDLE, FRAME} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [CW-1:0]   count_q, count_d;
  logic            flag_q, flag_d;
  logic [N-1:0]    f_d, chk_d;
  logic [CW-1:0]   cnt_d;
  logic            ovf_d, out_valid_d, out_last_d;
  logic [N-1:0]    res_c;
  logic            accept_c;
  logic [CW-1:0]   count_base;
  logic            flag_base;

  assign in_ready = !out_valid || out_ready;
  assign accept_c = in_valid && in_ready;

  // Per-bit operation selected by op
  always_comb begin
    res_c = '0;
    case (op)
      2'b00:   res_c = a ^ b;
      2'b01:   res_c = ~(a ^ b);
      2'b10:   res_c = a & b;
      default: res_c = a | b;
    endcase
  end

  // Next-state, frame accumulation and output register inputs
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    flag_d      = flag_q;
    f_d         = f;
    chk_d       = chk;
    cnt_d       = cnt;
    ovf_d       = ovf;
    out_valid_d = out_valid;
    out_last_d  = out_last;
    count_base  = count_q;
    flag_base   = flag_q;

    // The first word of a frame restarts the count; later words saturate at CNT_MAX
    if (state_q == IDLE) begin
      count_base = CW'(1);
      flag_base  = 1'b0;
    end else if (count_q == CNT_MAX) begin
      count_base = count_q;
      flag_base  = 1'b1;
    end else begin
      count_base = count_q + CW'(1);
      flag_base  = flag_q;
    end

    if (accept_c) begin
      f_d         = res_c;
      out_valid_d = 1'b1;
      out_last_d  = in_last;
      if (in_last) begin
        chk_d   = acc_q ^ res_c;
        cnt_d   = count_base;
        ovf_d   = flag_base;
        acc_d   = '0;
        count_d = '0;
        flag_d  = 1'b0;
        state_d = IDLE;
      end else begin
        acc_d   = acc_q ^ res_c;
        count_d = count_base;
        flag_d  = flag_base;
        state_d = FRAME;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      count_q   <= '0;
      flag_q    <= 1'b0;
      f         <= '0;
      chk       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      flag_q    <= flag_d;
      f         <= f_d;
      chk       <= chk_d;
      cnt       <= cnt_d;
      ovf       <= ovf_d;
      out_valid <= out_valid_d;
      out_last  <= out_last_d;
    end
  end

`ifdef XORN_STREAM_PARITY_EN
  // Parity tracks f: loaded with the word, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par <= 1'b0;
    end else if (accept_c) begin
      par <= ^res_c;
    end
  end
`endif

endmodule

// File: tb/tb_xorn_stream.sv
// Scoreboard bench for xorn_stream: a default-CW instance and a CW=2 instance share stimulus.
module tb_xorn_stream;

  logic        clk;
  logic        rst_n;
  logic [15:0] a, b;
  logic [1:0]  op;
  logic        in_valid, in_last, out_ready;
  logic        in_ready, out_valid, out_last, ovf;
  logic [15:0] f, chk;
  logic [7:0]  cnt;
  logic        in_ready2, out_valid2, out_last2, ovf2;
  logic [15:0] f2, chk2;
  logic [1:0]  cnt2;
`ifdef XORN_STREAM_PARITY_EN
  logic        par, par2;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] f;
    logic        last;
    logic [15:0] chk;
    logic [7:0]  cnt8;
    logic        ovf8;
    logic [1:0]  cnt2;
    logic        ovf2;
  } exp_t;

  exp_t        expq[$];
  logic [15:0] frame_res[$];
  logic [15:0] m_chk;
  logic [7:0]  m_cnt8;
  logic        m_ovf8;
  logic [1:0]  m_cnt2;
  logic        m_ovf2;

  xorn_stream #(.N(16), .CW(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .f(f), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .chk(chk), .cnt(cnt),
`ifdef XORN_STREAM_PARITY_EN
    .par(par),
`endif
    .ovf(ovf)
  );

  xorn_stream #(.N(16), .CW(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready2), .f(f2), .out_valid(out_valid2), .out_last(out_last2), .out_ready(out_ready),
    .chk(chk2), .cnt(cnt2),
`ifdef XORN_STREAM_PARITY_EN
    .par(par2),
`endif
    .ovf(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    frame_res.delete();
    expq.delete();
    m_chk = '0; m_cnt8 = '0; m_ovf8 = 1'b0; m_cnt2 = '0; m_ovf2 = 1'b0;
  endfunction

  // Reference: frame results kept as a list; sidebands derived from the whole frame at its last word
  function automatic void model_accept(input logic [15:0] aa, input logic [15:0] bb,
                                       input logic [1:0] oo, input logic ll);
    logic [15:0] r;
    exp_t e;
    int n;
    case (oo)
      2'd0:    r = aa ^ bb;
      2'd1:    r = ~(aa ^ bb);
      2'd2:    r = aa & bb;
      default: r = aa | bb;
    endcase
    frame_res.push_back(r);
    if (ll) begin
      m_chk = '0;
      foreach (frame_res[i]) m_chk ^= frame_res[i];
      n = frame_res.size();
      m_cnt8 = (n > 255) ? 8'd255 : 8'(n);
      m_ovf8 = (n > 255);
      m_cnt2 = (n > 3) ? 2'd3 : 2'(n);
      m_ovf2 = (n > 3);
      frame_res.delete();
    end
    e.f = r; e.last = ll; e.chk = m_chk;
    e.cnt8 = m_cnt8; e.ovf8 = m_ovf8; e.cnt2 = m_cnt2; e.ovf2 = m_ovf2;
    expq.push_back(e);
  endfunction

  // One clock: called at posedge+1, returns at next posedge+1
  task automatic cycle(input logic v, input logic [15:0] aa, input logic [15:0] bb, input logic [1:0] oo,
                       input logic ll, input logic rdy, output logic acc);
    a = aa; b = bb; op = oo; in_last = ll; in_valid = v; out_ready = rdy;
    #2;
    acc = v && in_ready;
    if (acc) model_accept(aa, bb, oo, ll);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] aa, input logic [15:0] bb, input logic [1:0] oo,
                      input logic ll, input int pr);
    logic acc;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++)
      cycle(1'b1, aa, bb, oo, ll, int'($urandom_range(99)) < pr, acc);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout word a=%h b=%h not accepted", aa, bb);
    end
  endtask

  task automatic idle(input logic rdy);
    logic acc;
    cycle(1'b0, 16'h0, 16'h0, 2'd0, 1'b0, rdy, acc);
  endtask

  // Direct look at the output registers right after a word was accepted
  task automatic check_out(input string tag, input logic [15:0] ef, input logic el, input logic [15:0] ec,
                           input logic [7:0] en, input logic eo, input logic [1:0] en2, input logic eo2);
    check({tag, "_valid"}, 32'(out_valid), 32'(1'b1));
    check({tag, "_f"}, 32'(f), 32'(ef));
    check({tag, "_last"}, 32'(out_last), 32'(el));
    check({tag, "_chk"}, 32'(chk), 32'(ec));
    check({tag, "_cnt"}, 32'(cnt), 32'(en));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    check({tag, "_cnt_cw2"}, 32'(cnt2), 32'(en2));
    check({tag, "_ovf_cw2"}, 32'(ovf2), 32'(eo2));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'(1'b0));
    check({tag, "_out_valid_cw2"}, 32'(out_valid2), 32'(1'b0));
    check({tag, "_f"}, 32'(f), 32'h0);
    check({tag, "_out_last"}, 32'(out_last), 32'h0);
    check({tag, "_chk"}, 32'(chk), 32'h0);
    check({tag, "_cnt"}, 32'(cnt), 32'h0);
    check({tag, "_ovf"}, 32'(ovf), 32'h0);
`ifdef XORN_STREAM_PARITY_EN
    check({tag, "_par"}, 32'(par), 32'h0);
`endif
  endtask

  initial begin
    logic acc;
    int len;
    a = '0; b = '0; op = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();

    // Monitor: compares every presented output word against the scoreboard head
    fork
      forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n && (out_valid || out_valid2)) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_output f=%h with no word expected", f);
          end else begin
            e = expq[0];
            check("mon_valid", 32'(out_valid), 32'(1'b1));
            check("mon_valid_cw2", 32'(out_valid2), 32'(1'b1));
            check("mon_f", 32'(f), 32'(e.f));
            check("mon_f_cw2", 32'(f2), 32'(e.f));
            check("mon_last", 32'(out_last), 32'(e.last));
            check("mon_chk", 32'(chk), 32'(e.chk));
            check("mon_chk_cw2", 32'(chk2), 32'(e.chk));
            check("mon_cnt", 32'(cnt), 32'(e.cnt8));
            check("mon_ovf", 32'(ovf), 32'(e.ovf8));
            check("mon_cnt_cw2", 32'(cnt2), 32'(e.cnt2));
            check("mon_ovf_cw2", 32'(ovf2), 32'(e.ovf2));
`ifdef XORN_STREAM_PARITY_EN
            check("mon_par", 32'(par), 32'(^e.f));
`endif
            if (out_ready) void'(expq.pop_front());
          end
        end
      end
    join_none

    #1 rst_n = 1'b0;
    #1 check_reset_state("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1 check("release_in_ready", 32'(in_ready), 32'(1'b1));
    @(posedge clk);
    #1;

    // Single-word frame
    send(16'haaaa, 16'h00ff, 2'd0, 1'b1, 100);
    check_out("single", 16'haa55, 1'b1, 16'haa55, 8'd1, 1'b0, 2'd1, 1'b0);
`ifdef XORN_STREAM_PARITY_EN
    check("single_par", 32'(par), 32'h0);
`endif

    // Two-word frame
    send(16'haaaa, 16'h00ff, 2'd0, 1'b0, 100);
    check_out("two_w0", 16'haa55, 1'b0, 16'haa55, 8'd1, 1'b0, 2'd1, 1'b0);
    send(16'h0f0f, 16'h3333, 2'd0, 1'b1, 100);
    check_out("two_w1", 16'h3c3c, 1'b1, 16'h9669, 8'd2, 1'b0, 2'd2, 1'b0);

    // Operation sweep
    send(16'h0f0f, 16'h3333, 2'd1, 1'b1, 100);
    check_out("xnor", 16'hc3c3, 1'b1, 16'hc3c3, 8'd1, 1'b0, 2'd1, 1'b0);
    send(16'h0f0f, 16'h3333, 2'd2, 1'b1, 100);
    check_out("and", 16'h0303, 1'b1, 16'h0303, 8'd1, 1'b0, 2'd1, 1'b0);
    send(16'h0f0f, 16'h3333, 2'd3, 1'b1, 100);
    check_out("or", 16'h3f3f, 1'b1, 16'h3f3f, 8'd1, 1'b0, 2'd1, 1'b0);

    // Backpressure: three stalled cycles, next word must wait
    send(16'haaaa, 16'h00ff, 2'd0, 1'b1, 100);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 16'h0f0f, 16'h3333, 2'd0, 1'b1, 1'b0, acc);
      check("stall_in_ready", 32'(acc), 32'(1'b0));
      check("stall_f_held", 32'(f), 32'(16'haa55));
      check("stall_chk_held", 32'(chk), 32'(16'haa55));
    end
    send(16'h0f0f, 16'h3333, 2'd0, 1'b1, 100);
    check_out("after_stall", 16'h3c3c, 1'b1, 16'h3c3c, 8'd1, 1'b0, 2'd1, 1'b0);

    // Five-word frame saturates the CW=2 counter
    for (int k = 0; k < 5; k++) send(16'(k * 16'h1111), 16'h00ff, 2'd0, k == 4, 100);
    check_out("five", 16'h44bb, 1'b1, m_chk, 8'd5, 1'b0, 2'd3, 1'b1);
    send(16'h1234, 16'h0000, 2'd3, 1'b1, 100);
    check_out("after_ovf", 16'h1234, 1'b1, 16'h1234, 8'd1, 1'b0, 2'd1, 1'b0);

    // Reset in the middle of a frame
    send(16'h5555, 16'h0f0f, 2'd0, 1'b0, 100);
    send(16'h1111, 16'h2222, 2'd3, 1'b0, 100);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_reset_state("midreset");
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b0;
    #1 check("midreset_in_ready", 32'(in_ready), 32'(1'b1));
    @(posedge clk);
    #1;
    send(16'haaaa, 16'h00ff, 2'd0, 1'b1, 100);
    check_out("post_reset", 16'haa55, 1'b1, 16'haa55, 8'd1, 1'b0, 2'd1, 1'b0);
`ifdef XORN_STREAM_PARITY_EN
    check("post_reset_par", 32'(par), 32'h0);
`endif

    // Random frames under random backpressure
    for (int fr = 0; fr < 40; fr++) begin
      len = int'($urandom_range(8, 1));
      for (int w = 0; w < len; w++)
        send(16'($urandom), 16'($urandom), 2'($urandom), w == len - 1, 70);
      if ($urandom_range(3) == 0) idle(1'($urandom));
    end

    // Long frame saturates the default counter
    for (int w = 0; w < 260; w++)
      send(16'($urandom), 16'($urandom), 2'($urandom), w == 259, 90);
    check("long_ovf", 32'(ovf), 32'(1'b1));
    check("long_cnt", 32'(cnt), 32'd255);

    repeat (5) idle(1'b1);
    check("drain_empty", 32'(expq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
